imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/imem_loader_word_assembler.sv | 32 +++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame: SYNC, LEN_LO, LEN_HI, 4*N little-endian payload bytes, XOR checksum.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN0 = 3'd1,
      ST_LEN1 = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
   localparam int         HDR_BYTES      = 3;
   localparam int         BYTES_PER_WORD = 4;
   localparam int         CSUM_BYTES     = 1;
   localparam int         ADDR_W         = 32;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; flags the 4th byte.
module word_assembler (
   input  logic        clk,
   input  logic        areset,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [1:0]  r_cnt;
   logic [23:0] r_shift;

   // The completing byte is combined directly so the word is ready in its own cycle.
   assign o_word       = {i_byte, r_shift};
   assign o_word_valid = i_valid && (r_cnt == 2'd3);

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_cnt   <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_clear) begin
         r_cnt   <= 2'd0;
         r_shift <= 24'd0;
      end else if (i_valid) begin
         r_cnt   <= r_cnt + 2'd1;
         r_shift <= {i_byte, r_shift[23:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed image byte stream and writes it into
// instruction memory, holding the core in reset until a good image is loaded.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         MAX_WORDS = 256,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic              clk,
   input  logic              areset,
   // rx_valid is a single-cycle strobe qualifying rx_data; there is no ready,
   // every strobed byte is consumed (or discarded) in the cycle it appears.
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              restart,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wd,
   output logic              core_hold,
   output logic              done,
   output logic              error,
   output logic [2:0]        o_dbg_state
);

   state_t            r_state, r_state_next;
   logic [15:0]       r_len;
   logic [15:0]       r_word_cnt;
   logic [7:0]        r_csum;
   logic              r_im_we;
   logic [ADDR_W-1:0] r_im_addr;
   logic [31:0]       r_im_wd;

   logic [15:0]       w_len;
   logic              w_restart;
   logic              w_asm_valid;
   logic              w_word_valid;
   logic [31:0]       w_word;
   logic              w_last_word;

   assign w_len       = {rx_data, r_len[7:0]};
   assign w_restart   = restart && (r_state == ST_DONE || r_state == ST_ERR);
   assign w_asm_valid = rx_valid && (r_state == ST_DATA);
   assign w_last_word = (r_word_cnt + 16'd1) == r_len;

   word_assembler u_asm (
      .clk          (clk),
      .areset       (areset),
      .i_clear      (w_restart),
      .i_valid      (w_asm_valid),
      .i_byte       (rx_data),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   always_ff @(posedge clk or posedge areset) begin
      if (areset) r_state <= ST_IDLE;
      else        r_state <= r_state_next;
   end

   always_comb begin
      r_state_next = r_state;
      case (r_state)
         ST_IDLE: if (rx_valid && rx_data == SYNC_BYTE) r_state_next = ST_LEN0;
         ST_LEN0: if (rx_valid) r_state_next = ST_LEN1;
         ST_LEN1: begin
            if (rx_valid) begin
               if ({1'b0, w_len} > 17'(MAX_WORDS)) r_state_next = ST_ERR;
               else if (w_len == 16'd0)            r_state_next = ST_CSUM;
               else                                r_state_next = ST_DATA;
            end
         end
         ST_DATA: if (w_word_valid && w_last_word) r_state_next = ST_CSUM;
         ST_CSUM: begin
            if (rx_valid) r_state_next = (rx_data == r_csum) ? ST_DONE : ST_ERR;
         end
         // Restart takes priority; any byte arriving here is dropped.
         ST_DONE, ST_ERR: if (restart) r_state_next = ST_IDLE;
         default: r_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_len      <= 16'd0;
         r_word_cnt <= 16'd0;
         r_csum     <= 8'd0;
         r_im_we    <= 1'b0;
         r_im_addr  <= '0;
         r_im_wd    <= 32'd0;
      end else begin
         r_im_we <= w_word_valid;
         if (w_word_valid) begin
            r_im_addr  <= {{(ADDR_W-18){1'b0}}, r_word_cnt, 2'b00};
            r_im_wd    <= w_word;
            r_word_cnt <= r_word_cnt + 16'd1;
         end
         if (w_asm_valid)                     r_csum      <= r_csum ^ rx_data;
         if (rx_valid && r_state == ST_LEN0)  r_len[7:0]  <= rx_data;
         if (rx_valid && r_state == ST_LEN1)  r_len[15:8] <= rx_data;
         if (w_restart) begin
            r_len      <= 16'd0;
            r_word_cnt <= 16'd0;
            r_csum     <= 8'd0;
         end
      end
   end

   assign im_we       = r_im_we;
   assign im_addr     = r_im_addr;
   assign im_wd       = r_im_wd;
   assign core_hold   = (r_state != ST_DONE);
   assign done        = (r_state == ST_DONE);
   assign error       = (r_state == ST_ERR);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed images, length/checksum errors,
// garbage before sync, mid-frame reset and restart priority.
module tb_imem_loader;
   import imem_loader_pkg::*;

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        restart = 1'b0;
   logic        im_we;
   logic [31:0] im_addr;
   logic [31:0] im_wd;
   logic        core_hold;
   logic        done;
   logic        error;
   logic [2:0]  o_dbg_state;

   int checks = 0;
   int errors = 0;
   int we_double = 0;
   logic prev_we = 1'b0;

   logic [7:0]  tx_q[$];
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];

   imem_loader dut (
      .clk         (clk),
      .areset      (areset),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .restart     (restart),
      .im_we       (im_we),
      .im_addr     (im_addr),
      .im_wd       (im_wd),
      .core_hold   (core_hold),
      .done        (done),
      .error       (error),
      .o_dbg_state (o_dbg_state)
   );

   always #5 clk = ~clk;

   // Write monitor: records every memory write away from the active edge.
   always @(negedge clk) begin
      if (im_we) got_q.push_back({im_addr, im_wd});
      if (im_we && prev_we) we_double++;
      prev_we = im_we;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_all();
      while (tx_q.size() > 0) send_byte(tx_q.pop_front());
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic check_status(input string tag, input logic [2:0] st,
                               input logic hold, input logic dn, input logic er);
      chk({tag, "_state"}, 64'(o_dbg_state), 64'(st));
      chk({tag, "_flags"}, 64'({core_hold, done, error}), 64'({hold, dn, er}));
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0)
         chk({tag, "_write"}, got_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_we"}, 64'(im_we), 64'(0));
      chk({tag, "_addr_wd"}, {im_addr, im_wd}, 64'(0));
      check_status(tag, 3'(ST_IDLE), 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state, observed while reset is held.
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      areset = 1'b0;
      @(negedge clk);

      // Two-word image; XOR of payload 13^93^10 = 0x90.
      tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
      exp_q.push_back({32'h0, 32'h00000013});
      exp_q.push_back({32'h4, 32'h00100093});
      send_all();
      check_writes("two_words");
      check_status("two_words", 3'(ST_DONE), 1'b0, 1'b1, 1'b0);
      chk("hold_addr_wd", {im_addr, im_wd}, {32'h4, 32'h00100093});

      // Empty image, correct checksum 0x00.
      pulse_restart();
      check_status("restart_done", 3'(ST_IDLE), 1'b1, 1'b0, 1'b0);
      tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_all();
      check_writes("empty_ok");
      check_status("empty_ok", 3'(ST_DONE), 1'b0, 1'b1, 1'b0);

      // Empty image, wrong checksum.
      pulse_restart();
      tx_q = '{8'hA5, 8'h00, 8'h00, 8'h01};
      send_all();
      check_writes("empty_bad");
      check_status("empty_bad", 3'(ST_ERR), 1'b1, 1'b0, 1'b1);

      // Length 257 exceeds depth: error right after LEN_HI.
      pulse_restart();
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h01);
      check_status("too_long", 3'(ST_ERR), 1'b1, 1'b0, 1'b1);
      tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
      send_all();
      check_writes("too_long");
      check_status("err_ignores_rx", 3'(ST_ERR), 1'b1, 1'b0, 1'b1);

      // Garbage before sync is discarded.
      pulse_restart();
      send_byte(8'h00);
      send_byte(8'hFF);
      check_status("garbage", 3'(ST_IDLE), 1'b1, 1'b0, 1'b0);
      tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
      exp_q.push_back({32'h0, 32'h44332211});
      send_all();
      check_writes("garbage_frame");
      check_status("garbage_frame", 3'(ST_DONE), 1'b0, 1'b1, 1'b0);

      // Reset mid-payload, then a stray byte and a fresh frame.
      pulse_restart();
      tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
      send_all();
      @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      areset = 1'b0;
      // csum DE^AD^BE^EF = 0x22
      tx_q = '{8'h33, 8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
      exp_q.push_back({32'h0, 32'hEFBEADDE});
      send_all();
      check_writes("after_reset");
      check_status("after_reset", 3'(ST_DONE), 1'b0, 1'b1, 1'b0);

      // Restart and a sync byte in the same cycle: restart wins, byte dropped.
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      restart  = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      restart  = 1'b0;
      check_status("restart_wins", 3'(ST_IDLE), 1'b1, 1'b0, 1'b0);

      // Restart mid-payload is ignored; load starts from address 0 again.
      // csum 01^02^03^04^05^06^07^08 = 0x08
      tx_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_all();
      pulse_restart();
      check_status("restart_in_data", 3'(ST_DATA), 1'b1, 1'b0, 1'b0);
      tx_q = '{8'h06, 8'h07, 8'h08, 8'h08};
      exp_q.push_back({32'h0, 32'h04030201});
      exp_q.push_back({32'h4, 32'h08070605});
      send_all();
      check_writes("reload");
      check_status("reload", 3'(ST_DONE), 1'b0, 1'b1, 1'b0);

      chk("we_never_double", 64'(we_double), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
